strided_fifo_loader: RTL and testbench
======================================

Name: strided_fifo_loader

Overview:
- Parametrised successor to the single-channel FIFO supplier. Streams a strided address range from a single-port buffer RAM into a downstream FIFO.
- Address range is base to end inclusive, with a programmable step and a programmable number of passes.
- Holds a 2-entry skid buffer so that RAM read latency and FIFO back-pressure never lose or duplicate a word.
- Sits between the global buffer and a PE-array input FIFO.

Parameters:
- WIDTH, 16, data word width
- ADDR_WIDTH, 16, buffer address width
- PASS_WIDTH, 8, width of the pass-repeat count

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches the configuration inputs when idle
- base_addr  in  ADDR_WIDTH  first address of a pass
- addr_step  in  ADDR_WIDTH  address increment
- end_addr  in  ADDR_WIDTH  last allowed address, inclusive
- pass_cnt  in  PASS_WIDTH  number of extra passes; total passes = pass_cnt+1
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the last word has been written to the FIFO
- mem_en  out  1  RAM read enable
- mem_addr  out  ADDR_WIDTH  RAM read address
- mem_rdata  in  WIDTH  RAM read data, valid exactly 1 cycle after mem_en
- full  in  1  downstream FIFO full
- w_en  out  1  FIFO write strobe
- to_fifo  out  WIDTH  FIFO write data

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; busy, done, mem_en, w_en = 0; mem_addr = 0.
  - Skid buffer emptied; in-flight read flag cleared.
  - RAM data returning after reset is discarded.
- Configuration:
  - start is accepted only in IDLE; it latches base_addr, addr_step, end_addr, pass_cnt.
  - start while busy is ignored.
- States: IDLE, LOAD, DRAIN, FINISH (one-hot encoded).
- IDLE:
  - On start with base_addr <= end_addr, go to LOAD with addr=base_addr and pass=0.
  - On start with base_addr > end_addr, go to FINISH with zero words written.
- LOAD: issue a read (mem_en=1, mem_addr=addr) when skid_cnt + inflight - pop < 2.
  - pop = w_en.
  - inflight = mem_en in the previous cycle.
- Address advance after each issued read:
  - next = addr + addr_step, computed at ADDR_WIDTH+1 bits.
  - If the sum carries out, or next > end_addr, or addr_step == 0, the pass ends.
  - At the end of a pass: if pass == pass_cnt, go to DRAIN; otherwise pass++ and addr=base_addr.
  - Otherwise addr=next.
- DRAIN: no new reads. When inflight=0 and skid_cnt=0, go to FINISH.
- FINISH: done=1 for exactly one cycle, then IDLE. busy=0 in FINISH and IDLE.
- Skid buffer (2-entry FIFO, registered):
  - When inflight=1, push mem_rdata.
  - w_en = (skid_cnt != 0) && !full; to_fifo = skid head.
  - Push and pop in the same cycle leave the count unchanged.
  - The skid buffer never overflows, by the issue rule above.
  - Output order is strictly address-issue order.
- Throughput and latency:
  - With full held low: first w_en 2 cycles after the first mem_en; 1 word per cycle sustained.
  - Total words = (passes) × (elements per pass).
- Back-pressure:
  - full may toggle on any cycle. While full=1, w_en=0 and to_fifo holds the head.
  - Issue stalls within 1 cycle of the skid buffer reaching 2 entries.
- Reset mid-operation: abandons the job immediately; no done pulse.

Test Plan:
- base=0, step=1, end=7, pass_cnt=0, full=0:
  - mem_addr 0..7 on consecutive cycles; w_en 8 cycles starting 2 cycles after the first mem_en; data in order; single done pulse; busy low after it.
- base=4, step=3, end=13, pass_cnt=2:
  - Address sequence 4,7,10,13 repeated 3 times; 12 writes; done once.
- Same as scenario 1 with full toggled 3 cycles high / 2 cycles low:
  - Exactly 8 writes; no loss or duplication; never more than 2 buffered words; mem_en stalls while full.
- Corner cases:
  - base=10, end=5: done asserted 2 cycles after start, zero w_en.
  - step=0, pass_cnt=3: 4 reads of base.
  - base=0xFFFE, step=4, end=0xFFFF: a single read at 0xFFFE (carry ends the pass).
- rst pulsed for 1 cycle mid-LOAD with data in flight:
  - Next cycle all outputs 0, state IDLE, no w_en from the stale mem_rdata, no done.
  - A new start works normally.
- start pulsed again while busy with different config:
  - Ignored; the original sequence completes unchanged.

Source files
------------

// File: rtl/strided_fifo_loader.sv
// strided_fifo_loader: streams a strided, multi-pass address range from a 1-cycle-latency RAM into a FIFO through a 2-entry skid buffer
module strided_fifo_loader #(
  parameter int WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int PASS_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] addr_step,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  input  logic [PASS_WIDTH-1:0] pass_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0]      mem_rdata,
  input  logic                  full,
  output logic                  w_en,
  output logic [WIDTH-1:0]      to_fifo
);
  localparam logic [3:0] S_IDLE = 4'b0001, S_LOAD = 4'b0010, S_DRAIN = 4'b0100, S_FINISH = 4'b1000;
  logic [3:0] state, state_n;
  logic [ADDR_WIDTH-1:0] base_r, step_r, end_r, addr;
  logic [PASS_WIDTH-1:0] pcnt_r, pass;
  logic inflight, pass_end, last_pass, room;
  logic [1:0] cnt;
  logic [WIDTH-1:0] d0, d1;
  logic [ADDR_WIDTH:0] sum;
  assign sum = {1'b0, addr} + {1'b0, step_r};
  assign pass_end = sum[ADDR_WIDTH] || sum[ADDR_WIDTH-1:0] > end_r || step_r == '0;
  assign last_pass = pass == pcnt_r;
  // words already buffered or still returning, minus the one leaving now, must leave a free slot
  assign room = ({1'b0, cnt} + {2'b0, inflight} - {2'b0, w_en}) < 3'd2;
  assign mem_addr = addr;
  always_ff @(posedge clk)
    if (rst) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state[0] && start) state_n = base_addr <= end_addr ? S_LOAD : S_FINISH;
    if (state[1] && mem_en && pass_end && last_pass) state_n = S_DRAIN;
    if (state[2] && !inflight && cnt == 2'd0) state_n = S_FINISH;
    if (state[3]) state_n = S_IDLE;
  end
  always_comb begin
    busy = state[1] || state[2];
    mem_en = state[1] && room;
    w_en = cnt != 2'd0 && !full;
    to_fifo = d0;
  end
  // done is registered off FINISH so the pulse lands two cycles after an empty-range start
  always_ff @(posedge clk)
    if (rst) begin
      done <= 1'b0;
      inflight <= 1'b0;
      cnt <= 2'd0;
      addr <= '0;
      pass <= '0;
      base_r <= '0;
      step_r <= '0;
      end_r <= '0;
      pcnt_r <= '0;
    end else begin
      done <= state[3];
      inflight <= mem_en;
      cnt <= cnt + {1'b0, inflight} - {1'b0, w_en};
      if (state[0] && start) begin
        base_r <= base_addr;
        step_r <= addr_step;
        end_r <= end_addr;
        pcnt_r <= pass_cnt;
        addr <= base_addr;
        pass <= '0;
      end else if (mem_en) begin
        addr <= pass_end ? base_r : sum[ADDR_WIDTH-1:0];
        if (pass_end && !last_pass) pass <= pass + PASS_WIDTH'(1);
      end
    end
  always_ff @(posedge clk) begin
    if (inflight && (cnt == 2'd0 || (cnt == 2'd1 && w_en))) d0 <= mem_rdata;
    else if (w_en) d0 <= d1;
    if (inflight && ((cnt == 2'd1 && !w_en) || (cnt == 2'd2 && w_en))) d1 <= mem_rdata;
  end
endmodule

// File: tb/tb_strided_fifo_loader.sv
// tb_strided_fifo_loader: scoreboard bench checking address order, data order, timing and back-pressure of strided_fifo_loader
module tb_strided_fifo_loader;
  logic clk = 0, rst = 1, start = 0, full = 0;
  logic [15:0] base_addr = 0, addr_step = 0, end_addr = 0, mem_addr, mem_rdata = 0, to_fifo;
  logic [7:0] pass_cnt = 0;
  logic busy, done, mem_en, w_en;
  logic [15:0] exp_addr[$], exp_data[$];
  int checks = 0, errors = 0, cyc = 0, wcount = 0, dcount = 0, rd_tot = 0, wr_tot = 0, prev_en = 0;
  int first_en = -1, last_en = -1, first_wr = -1, done_cyc = -1, start_cyc = 0;

  strided_fifo_loader #(.WIDTH(16), .ADDR_WIDTH(16), .PASS_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .addr_step(addr_step),
    .end_addr(end_addr), .pass_cnt(pass_cnt), .busy(busy), .done(done), .mem_en(mem_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .full(full), .w_en(w_en), .to_fifo(to_fifo)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ram(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  always @(posedge clk) cyc++;
  always @(posedge clk) mem_rdata <= mem_en ? ram(mem_addr) : 16'hDEAD;

  always @(negedge clk) if (!rst) begin
    checks++;
    if (rd_tot - prev_en - wr_tot > 2) begin
      errors++;
      $display("FAIL skid_occupancy got %0d max 2", rd_tot - prev_en - wr_tot);
    end
    if (mem_en) begin
      checks++;
      if (exp_addr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read addr %h exp none", mem_addr);
      end else if (mem_addr !== exp_addr[0]) begin
        errors++;
        $display("FAIL read_addr got %h exp %h", mem_addr, exp_addr[0]);
      end
      if (exp_addr.size() != 0) void'(exp_addr.pop_front());
      exp_data.push_back(ram(mem_addr));
      rd_tot++;
      if (first_en < 0) first_en = cyc;
      last_en = cyc;
    end
    prev_en = mem_en ? 1 : 0;
    if (w_en) begin
      checks++;
      if (exp_data.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write data %h exp none", to_fifo);
      end else if (to_fifo !== exp_data[0]) begin
        errors++;
        $display("FAIL write_data got %h exp %h", to_fifo, exp_data[0]);
      end
      if (exp_data.size() != 0) void'(exp_data.pop_front());
      wr_tot++;
      wcount++;
      if (first_wr < 0) first_wr = cyc;
    end
    if (done) begin
      dcount++;
      done_cyc = cyc;
    end
  end

  task automatic build(input logic [15:0] b, s, e, input logic [7:0] pc);
    logic [15:0] a;
    logic [16:0] n;
    if (b > e) return;
    for (int p = 0; p <= int'(pc); p++) begin
      a = b;
      forever begin
        exp_addr.push_back(a);
        n = {1'b0, a} + {1'b0, s};
        if (n[16] || n[15:0] > e || s == 16'd0) break;
        a = n[15:0];
      end
    end
  endtask

  task automatic run_job(input logic [15:0] b, s, e, input logic [7:0] pc, input bit bp, input bit interfere);
    int w0, d0, n_exp, phase;
    build(b, s, e, pc);
    n_exp = exp_addr.size();
    w0 = wcount;
    d0 = dcount;
    phase = 0;
    first_en = -1;
    first_wr = -1;
    @(posedge clk); #1;
    base_addr = b; addr_step = s; end_addr = e; pass_cnt = pc; start = 1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 0;
    checks++;
    if (busy !== (b <= e)) begin
      errors++;
      $display("FAIL busy_after_start got %b exp %b", busy, b <= e);
    end
    for (int i = 0; i < 3000 && dcount == d0; i++) begin
      @(posedge clk); #1;
      full = bp ? (phase < 3) : 1'b0;
      phase = (phase + 1) % 5;
      if (interfere && i == 2) begin
        base_addr = 16'd0; addr_step = 16'd1; end_addr = 16'd3; pass_cnt = 8'd0; start = 1;
      end else start = 0;
    end
    full = 0;
    start = 0;
    repeat (4) @(posedge clk);
    #1;
    checks += 5;
    if (dcount - d0 != 1) begin
      errors++;
      $display("FAIL done_pulses got %0d exp 1", dcount - d0);
    end
    if (wcount - w0 != n_exp) begin
      errors++;
      $display("FAIL word_count got %0d exp %0d", wcount - w0, n_exp);
    end
    if (exp_addr.size() != 0) begin
      errors++;
      $display("FAIL reads_missing got %0d left exp 0", exp_addr.size());
    end
    if (exp_data.size() != 0) begin
      errors++;
      $display("FAIL writes_missing got %0d left exp 0", exp_data.size());
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_done got %b exp 0", busy);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({busy, done, mem_en, w_en} !== 4'b0 || mem_addr !== 16'd0) begin
      errors++;
      $display("FAIL %s got busy%b done%b en%b wen%b addr%h exp all 0", tag, busy, done, mem_en, w_en, mem_addr);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset_state");
    #1 rst = 0;
  endtask

  task automatic test_basic;
    run_job(16'd0, 16'd1, 16'd7, 8'd0, 0, 0);
    checks += 2;
    if (first_wr - first_en != 2) begin
      errors++;
      $display("FAIL first_write_latency got %0d exp 2", first_wr - first_en);
    end
    if (last_en - first_en != 7) begin
      errors++;
      $display("FAIL read_span got %0d exp 7", last_en - first_en);
    end
  endtask

  task automatic test_multipass;
    run_job(16'd4, 16'd3, 16'd13, 8'd2, 0, 0);
  endtask

  task automatic test_backpressure;
    run_job(16'd0, 16'd1, 16'd7, 8'd0, 1, 0);
  endtask

  task automatic test_empty_range;
    int w0;
    w0 = wcount;
    run_job(16'd10, 16'd1, 16'd5, 8'd0, 0, 0);
    checks += 2;
    if (done_cyc != start_cyc + 2) begin
      errors++;
      $display("FAIL empty_done_delay got %0d exp 2", done_cyc - start_cyc);
    end
    if (wcount != w0) begin
      errors++;
      $display("FAIL empty_writes got %0d exp 0", wcount - w0);
    end
  endtask

  task automatic test_step_zero;
    run_job(16'd7, 16'd0, 16'd20, 8'd3, 0, 0);
  endtask

  task automatic test_carry;
    run_job(16'hFFFE, 16'd4, 16'hFFFF, 8'd0, 0, 0);
  endtask

  task automatic test_reset_mid;
    int w0, d0;
    build(16'd0, 16'd1, 16'd100, 8'd0);
    @(posedge clk); #1;
    base_addr = 0; addr_step = 1; end_addr = 100; pass_cnt = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    exp_addr.delete();
    exp_data.delete();
    rd_tot = 0; wr_tot = 0; prev_en = 0;
    w0 = wcount;
    d0 = dcount;
    @(negedge clk);
    check_idle_outputs("reset_mid_outputs");
    repeat (5) @(posedge clk);
    #1;
    checks += 2;
    if (wcount != w0) begin
      errors++;
      $display("FAIL stale_writes got %0d exp 0", wcount - w0);
    end
    if (dcount != d0) begin
      errors++;
      $display("FAIL reset_done got %0d exp 0", dcount - d0);
    end
    run_job(16'd2, 16'd2, 16'd9, 8'd1, 0, 0);
  endtask

  task automatic test_ignored_start;
    run_job(16'd4, 16'd3, 16'd13, 8'd2, 0, 1);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_multipass;
    test_backpressure;
    test_empty_range;
    test_step_zero;
    test_carry;
    test_reset_mid;
    test_ignored_start;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
